// File: rtl/svm_pkg.sv
// svm_pkg: shared defaults and the controller state encoding for the SVM
// classification controller and its helpers.
package svm_pkg;

    localparam int SVM_DATA_SIZE  = 32;
    localparam int SVM_ACCUM_SIZE = 64;
    localparam int SVM_NUM_FEAT   = 2;
    localparam int SVM_MAX_SV     = 256;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        STREAM = 3'd2,
        DRAIN  = 3'd3,
        DONE   = 3'd4
    } svm_state_e;

endpackage

// File: rtl/svm_skew_line.sv
// svm_skew_line: fixed-depth register delay line, cleared by synchronous reset.
// Used to skew the stage-0 control/operand bundle onto later pipeline stages.
module svm_skew_line #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] pipe_q [DEPTH];

    // Shift the input one slot per clock; reset flushes every slot to zero.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pipe_q[0] <= d_i;
            for (int i = 1; i < DEPTH; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign q_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/svm_ctrl.sv
// svm_ctrl: sequences one SVM classification through a chain of NUM_FEAT
// multiply-accumulate stages. Reads N support vectors from memory, streams
// feature i of each vector into stage i (stage i lags stage 0 by i cycles),
// waits for the chain to drain and offers the final accumulator on a
// valid/ready handshake.
// Optional build macro: SVM_CTRL_BIAS_EN adds a signed bias input, adds it to
// the result and exposes the class decision on res_class.
module svm_ctrl
    import svm_pkg::*;
#(
    parameter int DATA_SIZE  = SVM_DATA_SIZE,
    parameter int ACCUM_SIZE = SVM_ACCUM_SIZE,
    parameter int NUM_FEAT   = SVM_NUM_FEAT,
    parameter int MAX_SV     = SVM_MAX_SV,
    localparam int SVA_W     = $clog2(MAX_SV)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [SVA_W:0]                num_sv,
    input  logic [NUM_FEAT*DATA_SIZE-1:0] vec_in,
    output logic                          busy,
    output logic                          err,
    output logic                          sv_rd_en,
    output logic [SVA_W-1:0]              sv_addr,
    input  logic [NUM_FEAT*DATA_SIZE-1:0] sv_rdata,
    output logic [NUM_FEAT-1:0]           stage_start,
    output logic [NUM_FEAT-1:0]           stage_last,
    output logic [NUM_FEAT*DATA_SIZE-1:0] stage_sv,
    output logic [NUM_FEAT*DATA_SIZE-1:0] vec_out,
    output logic [ACCUM_SIZE-1:0]         accum_seed,
    input  logic [ACCUM_SIZE-1:0]         accum_fin,
`ifdef SVM_CTRL_BIAS_EN
    input  logic signed [ACCUM_SIZE-1:0]  bias,
    output logic                          res_class,
`endif
    output logic                          res_valid,
    input  logic                          res_ready,
    output logic [ACCUM_SIZE-1:0]         res_data
);

    localparam logic [SVA_W:0] MinSv     = (SVA_W+1)'(2);
    localparam logic [SVA_W:0] MaxSv     = (SVA_W+1)'(MAX_SV);
    localparam logic [SVA_W:0] DrainLast = (SVA_W+1)'(NUM_FEAT - 1);
    localparam logic [SVA_W:0] One       = (SVA_W+1)'(1);

    svm_state_e                    state_q, state_d;
    logic [SVA_W:0]                cnt_q, cnt_d;
    logic [SVA_W:0]                n_q, n_d;
    logic [NUM_FEAT*DATA_SIZE-1:0] vec_q, vec_d;
    logic                          err_q, err_d;
    logic [ACCUM_SIZE-1:0]         res_data_q, res_data_d;
    logic [ACCUM_SIZE-1:0]         result;
    logic [SVA_W:0]                nLast;
    logic                          streaming;
    logic                          start0;
    logic                          last0;

`ifdef SVM_CTRL_BIAS_EN
    logic [ACCUM_SIZE-1:0] bias_q, bias_d;

    // Final result: chain output plus the bias captured with the request.
    always_comb begin
        result = accum_fin + bias_q;
    end
`else
    // Final result is the chain output unchanged.
    always_comb begin
        result = accum_fin;
    end
`endif

    assign nLast     = n_q - One;
    assign streaming = (state_q == STREAM);

    // State register and datapath captures; reset abandons any operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            n_q        <= '0;
            vec_q      <= '0;
            err_q      <= 1'b0;
            res_data_q <= '0;
`ifdef SVM_CTRL_BIAS_EN
            bias_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            n_q        <= n_d;
            vec_q      <= vec_d;
            err_q      <= err_d;
            res_data_q <= res_data_d;
`ifdef SVM_CTRL_BIAS_EN
            bias_q     <= bias_d;
`endif
        end
    end

    // Next-state logic: start is only honoured in IDLE; bad counts are rejected.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        n_d        = n_q;
        vec_d      = vec_q;
        err_d      = 1'b0;
        res_data_d = res_data_q;
`ifdef SVM_CTRL_BIAS_EN
        bias_d     = bias_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    if ((num_sv < MinSv) || (num_sv > MaxSv)) begin
                        err_d = 1'b1;
                    end else begin
                        n_d     = num_sv;
                        vec_d   = vec_in;
`ifdef SVM_CTRL_BIAS_EN
                        bias_d  = bias;
`endif
                        cnt_d   = '0;
                        state_d = FETCH;
                    end
                end
            end
            FETCH: begin
                cnt_d   = '0;
                state_d = STREAM;
            end
            STREAM: begin
                if (cnt_q == nLast) begin
                    cnt_d   = '0;
                    state_d = DRAIN;
                end else begin
                    cnt_d = cnt_q + One;
                end
            end
            DRAIN: begin
                if (cnt_q == DrainLast) begin
                    res_data_d = result;
                    state_d    = DONE;
                end else begin
                    cnt_d = cnt_q + One;
                end
            end
            DONE: begin
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Memory read strobe runs one vector ahead of the stream; stage-0 markers.
    always_comb begin
        sv_rd_en = 1'b0;
        sv_addr  = '0;
        start0   = 1'b0;
        last0    = 1'b0;
        case (state_q)
            FETCH: begin
                sv_rd_en = 1'b1;
            end
            STREAM: begin
                start0 = (cnt_q == '0);
                last0  = (cnt_q == nLast);
                if (cnt_q != nLast) begin
                    sv_rd_en = 1'b1;
                    sv_addr  = SVA_W'(cnt_q + One);
                end
            end
            default: begin
                sv_rd_en = 1'b0;
            end
        endcase
    end

    for (genvar i = 0; i < NUM_FEAT; i++) begin : g_stage
        logic [DATA_SIZE-1:0] featSv;

        assign featSv = streaming ? sv_rdata[i*DATA_SIZE +: DATA_SIZE] : '0;

        if (i == 0) begin : g_direct
            assign stage_start[0]                = start0;
            assign stage_last[0]                 = last0;
            assign stage_sv[0 +: DATA_SIZE]      = featSv;
        end else begin : g_skew
            logic [DATA_SIZE+1:0] skewOut;

            svm_skew_line #(
                .WIDTH (DATA_SIZE + 2),
                .DEPTH (i)
            ) u_skew (
                .clk_i (clk),
                .rst_i (rst),
                .d_i   ({start0, last0, featSv}),
                .q_o   (skewOut)
            );

            assign stage_start[i]                     = skewOut[DATA_SIZE+1];
            assign stage_last[i]                      = skewOut[DATA_SIZE];
            assign stage_sv[i*DATA_SIZE +: DATA_SIZE] = skewOut[DATA_SIZE-1:0];
        end
    end

    assign busy       = (state_q != IDLE);
    assign err        = err_q;
    assign res_valid  = (state_q == DONE);
    assign res_data   = res_data_q;
    assign vec_out    = vec_q;
    assign accum_seed = '0;
`ifdef SVM_CTRL_BIAS_EN
    assign res_class  = ~res_data_q[ACCUM_SIZE-1];
`endif

endmodule

// File: tb/tb_svm_ctrl.sv
// tb_svm_ctrl: directed bench for svm_ctrl with a support-vector memory model
// and a two-stage multiply-accumulate chain model feeding accum_fin.
// Build with SVM_CTRL_BIAS_EN defined to also exercise the bias/class path.
module tb_svm_ctrl;

    localparam int DW  = 32;
    localparam int AW  = 64;
    localparam int NF  = 2;
    localparam int MSV = 256;
    localparam int SW  = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [SW:0]    numSv;
    logic [NF*DW-1:0] vecIn;
    logic           busy;
    logic           err;
    logic           svRdEn;
    logic [SW-1:0]  svAddr;
    logic [NF*DW-1:0] svRdata = '0;
    logic [NF-1:0]  stageStart;
    logic [NF-1:0]  stageLast;
    logic [NF*DW-1:0] stageSv;
    logic [NF*DW-1:0] vecOut;
    logic [AW-1:0]  accumSeed;
    logic [AW-1:0]  accumFin;
    logic           resValid;
    logic           resReady;
    logic [AW-1:0]  resData;
`ifdef SVM_CTRL_BIAS_EN
    logic [AW-1:0]  bias;
    logic           resClass;
`endif

    logic [NF*DW-1:0] mem [MSV];
    logic [AW-1:0]  acc0 = '0;
    logic [AW-1:0]  acc1 = '0;

    int cyc = 0;
    int startCyc = 0;
    int compareCount = 0;
    int mismatchCount = 0;
    int hits [MSV];
    int reads = 0;
    int lastCyc = -1;
    int latency = 0;

    svm_ctrl #(
        .DATA_SIZE  (DW),
        .ACCUM_SIZE (AW),
        .NUM_FEAT   (NF),
        .MAX_SV     (MSV)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .num_sv      (numSv),
        .vec_in      (vecIn),
        .busy        (busy),
        .err         (err),
        .sv_rd_en    (svRdEn),
        .sv_addr     (svAddr),
        .sv_rdata    (svRdata),
        .stage_start (stageStart),
        .stage_last  (stageLast),
        .stage_sv    (stageSv),
        .vec_out     (vecOut),
        .accum_seed  (accumSeed),
        .accum_fin   (accumFin),
`ifdef SVM_CTRL_BIAS_EN
        .bias        (bias),
        .res_class   (resClass),
`endif
        .res_valid   (resValid),
        .res_ready   (resReady),
        .res_data    (resData)
    );

    always #5 clk = ~clk;

    // Free-running cycle counter used to time events relative to a start.
    always @(posedge clk) cyc <= cyc + 1;

    // Support-vector memory: registered read, data one cycle after the strobe.
    always @(posedge clk) begin
        if (svRdEn) svRdata <= mem[svAddr];
    end

    // Stage chain: each stage accumulates sv*feature, restarting on start_inner.
    always @(posedge clk) begin
        acc0 <= (stageStart[0] ? '0 : acc0) + AW'(stageSv[DW-1:0]) * AW'(vecOut[DW-1:0]);
        acc1 <= (stageStart[1] ? '0 : acc1) + AW'(stageSv[2*DW-1:DW]) * AW'(vecOut[2*DW-1:DW]);
    end

    assign accumFin = accumSeed + acc0 + acc1;

    // Record every memory read address and when stage 1 sees its last operand.
    always @(negedge clk) begin
        if (svRdEn) begin
            hits[svAddr] = hits[svAddr] + 1;
            reads = reads + 1;
        end
        if (stageLast[1] && lastCyc < 0) lastCyc = cyc - startCyc;
    end

    task automatic checkOutput(input string tag, input logic [AW-1:0] observed,
                               input logic [AW-1:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got %0h, want %0h", tag, observed, expected);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Present a start for one cycle (cycle 0); returns #1 into cycle 1.
    task automatic applyStimulus(input logic [SW:0] n, input logic [NF*DW-1:0] v);
        start    = 1'b1;
        numSv    = n;
        vecIn    = v;
        startCyc = cyc;
        waitCycles(1);
        start = 1'b0;
    endtask

    task automatic waitForValid(input int limit);
        for (int i = 0; i < limit; i++) begin
            if (resValid) break;
            waitCycles(1);
        end
        latency = cyc - startCyc;
        checkOutput("validReached", AW'(resValid), 64'd1);
    endtask

    initial begin
        int badCount;
        int seenValid;
        rst = 1'b1; start = 1'b0; numSv = '0; vecIn = '0; resReady = 1'b0;
`ifdef SVM_CTRL_BIAS_EN
        bias = '0;
`endif
        for (int i = 0; i < MSV; i++) begin
            mem[i] = '0;
            hits[i] = 0;
        end
        @(posedge clk); #1;
        waitCycles(2);
        checkOutput("rstBusy", AW'(busy), 64'd0);
        checkOutput("rstErr", AW'(err), 64'd0);
        checkOutput("rstValid", AW'(resValid), 64'd0);
        checkOutput("rstRdEn", AW'(svRdEn), 64'd0);
        checkOutput("rstResData", resData, 64'd0);
        checkOutput("rstVecOut", AW'(vecOut), 64'd0);
        rst = 1'b0;
        waitCycles(1);

        // Two vectors {7,3},{2,5} against {1,4}: 7+12+2+20 = 41.
        mem[0] = {32'd3, 32'd7};
        mem[1] = {32'd5, 32'd2};
        applyStimulus(9'd2, {32'd4, 32'd1});
        checkOutput("c1Busy", AW'(busy), 64'd1);
        checkOutput("c1RdEn", AW'(svRdEn), 64'd1);
        checkOutput("c1Addr", AW'(svAddr), 64'd0);
        checkOutput("c1Start", AW'(stageStart), 64'd0);
        waitCycles(1);
        checkOutput("c2Start", AW'(stageStart), 64'd1);
        checkOutput("c2Sv", AW'(stageSv), {32'd0, 32'd7});
        checkOutput("c2RdEn", AW'(svRdEn), 64'd1);
        checkOutput("c2Addr", AW'(svAddr), 64'd1);
        waitCycles(1);
        checkOutput("c3Start", AW'(stageStart), 64'd2);
        checkOutput("c3Last", AW'(stageLast), 64'd1);
        checkOutput("c3Sv", AW'(stageSv), {32'd3, 32'd2});
        checkOutput("c3RdEn", AW'(svRdEn), 64'd0);
        waitCycles(1);
        checkOutput("c4Last", AW'(stageLast), 64'd2);
        checkOutput("c4Sv", AW'(stageSv), {32'd5, 32'd0});
        checkOutput("c4Valid", AW'(resValid), 64'd0);
        waitCycles(1);
        checkOutput("c5Valid", AW'(resValid), 64'd0);
        waitCycles(1);
        checkOutput("c6Valid", AW'(resValid), 64'd1);
        checkOutput("c6Data", resData, 64'd41);
        start = 1'b1; numSv = 9'd1;
        for (int c = 7; c <= 10; c++) begin
            waitCycles(1);
            start = 1'b0;
            checkOutput("doneValid", AW'(resValid), 64'd1);
            checkOutput("doneData", resData, 64'd41);
            checkOutput("doneErr", AW'(err), 64'd0);
        end
        resReady = 1'b1; start = 1'b1; numSv = 9'd2;
        waitCycles(1);
        start = 1'b0; resReady = 1'b0;
        checkOutput("hsBusy", AW'(busy), 64'd0);
        checkOutput("hsValid", AW'(resValid), 64'd0);
        checkOutput("hsVecOut", AW'(vecOut), {32'd4, 32'd1});
        waitCycles(1);
        checkOutput("hsIgnored", AW'(busy), 64'd0);
        checkOutput("hsNoRead", AW'(svRdEn), 64'd0);

        // Rejected counts: 1, 257 and 0.
        applyStimulus(9'd1, {32'd4, 32'd1});
        checkOutput("n1Err", AW'(err), 64'd1);
        checkOutput("n1Busy", AW'(busy), 64'd0);
        checkOutput("n1RdEn", AW'(svRdEn), 64'd0);
        waitCycles(1);
        checkOutput("n1ErrEnd", AW'(err), 64'd0);
        checkOutput("n1BusyEnd", AW'(busy), 64'd0);
        applyStimulus(9'd257, {32'd4, 32'd1});
        checkOutput("n257Err", AW'(err), 64'd1);
        checkOutput("n257Busy", AW'(busy), 64'd0);
        applyStimulus(9'd0, {32'd4, 32'd1});
        checkOutput("n0Err", AW'(err), 64'd1);
        waitCycles(1);

        // Full-depth run: sum of 1*3 + k*2 for k=0..255 = 66048.
        for (int k = 0; k < MSV; k++) begin
            mem[k] = {32'(k), 32'd1};
            hits[k] = 0;
        end
        reads = 0;
        lastCyc = -1;
        resReady = 1'b1;
        applyStimulus(9'd256, {32'd2, 32'd3});
        waitForValid(400);
        checkOutput("maxLatency", AW'(latency), 64'd260);
        checkOutput("maxData", resData, 64'd66048);
        badCount = 0;
        for (int k = 0; k < MSV; k++) begin
            if (hits[k] != 1) badCount++;
        end
        checkOutput("maxAddrOnce", AW'(badCount), 64'd0);
        checkOutput("maxReads", AW'(reads), 64'd256);
        checkOutput("maxLast1Cyc", AW'(lastCyc), 64'd258);
        waitCycles(1);
        checkOutput("maxIdle", AW'(busy), 64'd0);

        // Reset during STREAM cycle 3 of a four-vector run.
        mem[0] = {32'd3, 32'd7};
        mem[1] = {32'd5, 32'd2};
        applyStimulus(9'd4, {32'd4, 32'd1});
        waitCycles(4);
        rst = 1'b1;
        waitCycles(1);
        checkOutput("cutBusy", AW'(busy), 64'd0);
        checkOutput("cutRdEn", AW'(svRdEn), 64'd0);
        checkOutput("cutAddr", AW'(svAddr), 64'd0);
        checkOutput("cutStart", AW'(stageStart), 64'd0);
        checkOutput("cutLast", AW'(stageLast), 64'd0);
        checkOutput("cutSv", AW'(stageSv), 64'd0);
        checkOutput("cutVecOut", AW'(vecOut), 64'd0);
        checkOutput("cutValid", AW'(resValid), 64'd0);
        checkOutput("cutData", resData, 64'd0);
        rst = 1'b0;
        seenValid = 0;
        for (int c = 0; c < 10; c++) begin
            waitCycles(1);
            if (resValid) seenValid = 1;
        end
        checkOutput("cutNoResult", AW'(seenValid), 64'd0);
        applyStimulus(9'd2, {32'd4, 32'd1});
        waitForValid(20);
        checkOutput("freshLatency", AW'(latency), 64'd6);
        checkOutput("freshData", resData, 64'd41);
        waitCycles(1);

`ifdef SVM_CTRL_BIAS_EN
        // Bias -50 on a sum of 41 gives -9, a negative class.
        bias = -64'sd50;
        applyStimulus(9'd2, {32'd4, 32'd1});
        bias = '0;
        waitForValid(20);
        checkOutput("biasData", resData, 64'hFFFF_FFFF_FFFF_FFF7);
        checkOutput("biasClass", AW'(resClass), 64'd0);
        waitCycles(1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
